// File: rtl/lfsr_range_rng.sv
// Pseudo-random sample generator: XNOR Fibonacci LFSR stepped STEPS times per request,
// reduced into 0..RANGE_MAX by repeated subtraction, returned with a req/valid handshake.
module lfsr_range_rng #(
    parameter int unsigned           WIDTH     = 9,
    parameter logic [WIDTH-1:0]      TAPS      = WIDTH'(9'h110),
    parameter logic [WIDTH-1:0]      SEED      = '0,
    parameter int unsigned           STEPS     = 1,
    parameter int unsigned           RANGE_MAX = 320
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    output logic             busy,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_value,
    output logic [WIDTH-1:0] lfsr_state
);

    localparam int unsigned      CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(STEPS - 1);
    localparam logic [WIDTH-1:0] LIMIT    = WIDTH'(RANGE_MAX);
    localparam logic [WIDTH-1:0] MODULUS  = WIDTH'(RANGE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REDUCE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] lfsr_n, lfsr_step;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] out_value_n;
    logic             out_valid_n;

    // One XNOR-feedback shift of the current LFSR contents; never yields all-ones.
    always_comb begin
        lfsr_step = {lfsr_state[WIDTH-2:0], ~^(lfsr_state & TAPS)};
    end

    // Next-state and datapath decisions; seed_load overrides everything in flight.
    always_comb begin
        state_n     = state;
        lfsr_n      = lfsr_state;
        acc_n       = acc;
        cnt_n       = cnt;
        out_value_n = out_value;
        out_valid_n = 1'b0;

        if (seed_load) begin
            lfsr_n  = (&seed) ? '0 : seed;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state_n = SHIFT;
                        cnt_n   = CNT_INIT;
                    end
                end
                SHIFT: begin
                    lfsr_n = lfsr_step;
                    if (cnt != '0) begin
                        cnt_n = cnt - CNT_W'(1);
                    end else begin
                        acc_n   = lfsr_step;
                        state_n = REDUCE;
                    end
                end
                REDUCE: begin
                    if (acc > LIMIT) begin
                        acc_n = acc - MODULUS;
                    end else begin
                        out_value_n = acc;
                        out_valid_n = 1'b1;
                        state_n     = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State and output registers; busy is registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lfsr_state <= SEED;
            acc        <= '0;
            cnt        <= '0;
            out_value  <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            lfsr_state <= lfsr_n;
            acc        <= acc_n;
            cnt        <= cnt_n;
            out_value  <= out_value_n;
            out_valid  <= out_valid_n;
            busy       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Scoreboard bench for lfsr_range_rng: STEPS=1 and STEPS=3 instances, directed cases
// followed by a randomized soak checked against an arithmetic reference model.
module tb_lfsr_range_rng;

    localparam int unsigned      W    = 9;
    localparam int unsigned      RMAX = 320;
    localparam logic [W-1:0]     TAPS = 9'h110;

    typedef struct {
        logic [W-1:0] val;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         seed_load [2];
    logic [W-1:0] seed      [2];
    logic         req       [2];
    logic         busy      [2];
    logic         out_valid [2];
    logic [W-1:0] out_value [2];
    logic [W-1:0] lfsr_state[2];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t mon_e;
    logic prev_valid[2];
    int   busy_cnt[2];
    int   busy_last[2];
    logic [W-1:0] mlfsr[2];
    logic [W-1:0] last_val[2];

    lfsr_range_rng #(.WIDTH(W), .TAPS(TAPS), .SEED(9'd0), .STEPS(1), .RANGE_MAX(RMAX)) dut1 (
        .clk(clk), .reset(reset), .seed_load(seed_load[0]), .seed(seed[0]), .req(req[0]),
        .busy(busy[0]), .out_valid(out_valid[0]), .out_value(out_value[0]),
        .lfsr_state(lfsr_state[0])
    );

    lfsr_range_rng #(.WIDTH(W), .TAPS(TAPS), .SEED(9'd0), .STEPS(3), .RANGE_MAX(RMAX)) dut3 (
        .clk(clk), .reset(reset), .seed_load(seed_load[1]), .seed(seed[1]), .req(req[1]),
        .busy(busy[1]), .out_valid(out_valid[1]), .out_value(out_value[1]),
        .lfsr_state(lfsr_state[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int steps_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Reference LFSR: new bit is 1 when an even number of tapped bits are set.
    function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
        logic fb;
        fb = (($countones(s & TAPS) % 2) == 0);
        return {s[W-2:0], fb};
    endfunction

    // Monitor: pops the scoreboard on every out_valid and checks value, timing and invariants.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                if (out_valid[d]) begin
                    check("out_range", int'(out_value[d] <= W'(RMAX)), 1);
                    check("valid_twice", int'(prev_valid[d]), 0);
                    if (qsize(d) == 0) begin
                        check("unexpected_valid", int'(out_valid[d]), 0);
                    end else begin
                        if (d == 0) mon_e = q0.pop_front();
                        else        mon_e = q1.pop_front();
                        check("out_value", int'(out_value[d]), int'(mon_e.val));
                        check("latency_cycle", cyc, mon_e.due);
                    end
                    busy_last[d] = busy_cnt[d];
                    busy_cnt[d]  = 0;
                end else if (busy[d]) begin
                    busy_cnt[d] = busy_cnt[d] + 1;
                end else begin
                    busy_cnt[d] = 0;
                end
                prev_valid[d] = out_valid[d];
            end else begin
                prev_valid[d] = 1'b0;
                busy_cnt[d]   = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy[d] && n < 1000) begin
            tick();
            n++;
        end
        if (busy[d]) check("idle_timeout", int'(busy[d]), 0);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while ((busy[d] || qsize(d) != 0) && n < 1000) begin
            tick();
            n++;
        end
        check("done_timeout", qsize(d), 0);
    endtask

    // Issue one accepted request and enqueue its expected value and due cycle.
    task automatic issue_req(input int d, input bit extra);
        logic [W-1:0] v;
        exp_t e;
        int   n;
        wait_idle(d);
        for (int s = 0; s < steps_of(d); s++) mlfsr[d] = model_step(mlfsr[d]);
        v = mlfsr[d];
        req[d] = 1'b1;
        tick();
        n = cyc;
        req[d] = 1'b0;
        e.val = W'(int'(v) % int'(RMAX + 1));
        e.due = n + steps_of(d) + 1 + int'(v) / int'(RMAX + 1);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        last_val[d] = e.val;
        if (extra) begin
            req[d] = 1'b1;
            tick();
            req[d] = 1'b0;
        end
    endtask

    task automatic load_seed(input int d, input logic [W-1:0] s, input logic with_req);
        seed_load[d] = 1'b1;
        seed[d]      = s;
        req[d]       = with_req;
        tick();
        seed_load[d] = 1'b0;
        req[d]       = 1'b0;
        mlfsr[d]     = (s == '1) ? '0 : s;
        check("lfsr_after_load", int'(lfsr_state[d]), int'(mlfsr[d]));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] old;
        int           period;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            seed_load[d] = 1'b0;
            seed[d]      = '0;
            req[d]       = 1'b0;
            mlfsr[d]     = '0;
            last_val[d]  = '0;
            busy_cnt[d]  = 0;
            busy_last[d] = 0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int d = 0; d < 2; d++) begin
            check("rst_busy", int'(busy[d]), 0);
            check("rst_valid", int'(out_valid[d]), 0);
            check("rst_value", int'(out_value[d]), 0);
            check("rst_lfsr", int'(lfsr_state[d]), 0);
        end

        // Back-to-back requests from the reset seed: 1, 3, 7, 15.
        for (int i = 0; i < 4; i++) issue_req(0, 1'b0);
        wait_done(0);
        check("seq_last", int'(out_value[0]), 15);
        repeat (3) tick();
        check("lfsr_holds_idle", int'(lfsr_state[0]), int'(mlfsr[0]));

        load_seed(0, 9'd416, 1'b0);
        issue_req(0, 1'b0);
        wait_done(0);
        check("bound_320", int'(out_value[0]), 320);
        load_seed(0, 9'd160, 1'b0);
        issue_req(0, 1'b0);
        wait_done(0);
        check("bound_321", int'(out_value[0]), 0);

        load_seed(0, 9'd510, 1'b0);
        issue_req(0, 1'b0);
        wait_done(0);
        check("reduce_188", int'(out_value[0]), 188);
        check("busy_cycles", busy_last[0], 3);

        load_seed(0, 9'h1FF, 1'b0);
        check("lockup_guard", int'(lfsr_state[0]), 0);
        issue_req(0, 1'b0);
        wait_done(0);
        check("after_lockup", int'(out_value[0]), 1);

        // Abort an in-flight request with seed_load; nothing must come out.
        old = out_value[0];
        req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        check("abort_busy_hi", int'(busy[0]), 1);
        load_seed(0, 9'h055, 1'b0);
        tick();
        check("abort_busy_lo", int'(busy[0]), 0);
        repeat (5) tick();
        check("abort_value_kept", int'(out_value[0]), int'(old));
        load_seed(0, 9'h0AA, 1'b1);
        repeat (5) tick();
        check("load_wins_busy", int'(busy[0]), 0);
        check("load_wins_value", int'(out_value[0]), int'(old));
        issue_req(0, 1'b1);
        wait_done(0);
        check("ignored_req_lfsr", int'(lfsr_state[0]), int'(mlfsr[0]));

        issue_req(1, 1'b0);
        wait_done(1);
        check("steps3_value", int'(out_value[1]), 7);
        check("steps3_lfsr", int'(lfsr_state[1]), 7);

        // Period walk from state 0, then randomized soak.
        load_seed(0, 9'd0, 1'b0);
        period = 0;
        for (int j = 1; j <= 511; j++) begin
            issue_req(0, 1'b0);
            wait_done(0);
            check("walk_lfsr", int'(lfsr_state[0]), int'(mlfsr[0]));
            if (period == 0 && lfsr_state[0] == '0) period = j;
        end
        check("lfsr_period", period, 511);

        for (int j = 0; j < 9489; j++) begin
            if ($urandom_range(0, 49) == 0) begin
                wait_done(0);
                load_seed(0, W'($urandom_range(0, 511)), 1'b0);
            end
            issue_req(0, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) tick();
        end
        wait_done(0);
        check("soak_lfsr", int'(lfsr_state[0]), int'(mlfsr[0]));
        check("sb_empty_1", q0.size(), 0);
        check("sb_empty_3", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
